// File: rtl/umi_pkg.sv
// Shared UMI field widths and the one-hot port select helper.
package umi_pkg;

  localparam int UMI_CW = 32;
  localparam int UMI_AW = 64;
  localparam int UMI_DW = 256;

  // Returns zero for an index at or beyond n, so callers can use |result as "routable".
  function automatic logic [15:0] onehot_idx(input logic [3:0] idx, input int n);
    logic [15:0] o;
    o = '0;
    if (int'(idx) < n) o[idx] = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/umi_demux_stage.sv
// Generic W-bit valid/ready register slice.
// UMI_DEMUX_SKID_EN adds a skid entry and makes in_ready a pure register output.
module umi_demux_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_full;
  logic [W-1:0] main_data;
  logic         push;
  logic         pop;

  assign push      = in_valid & in_ready;
  assign pop       = main_full & out_ready;
  assign out_valid = main_full;
  assign out_data  = main_data;

`ifdef UMI_DEMUX_SKID_EN
  logic         skid_full;
  logic [W-1:0] skid_data;

  assign in_ready = ~skid_full;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      main_full <= 1'b0;
      skid_full <= 1'b0;
    end else if (skid_full) begin
      if (pop) skid_full <= 1'b0;
    end else if (push) begin
      main_full <= 1'b1;
      if (main_full && !pop) skid_full <= 1'b1;
    end else if (pop) begin
      main_full <= 1'b0;
    end
  end

  // Skid always holds the younger packet, so it refills main before any new input.
  always_ff @(posedge clk) begin
    if (skid_full) begin
      if (pop) main_data <= skid_data;
    end else if (push) begin
      if (!main_full || pop) main_data <= in_data;
      else                   skid_data <= in_data;
    end
  end
`else
  assign in_ready = ~main_full | out_ready;

  always_ff @(posedge clk) begin
    if (!nreset)   main_full <= 1'b0;
    else if (push) main_full <= 1'b1;
    else if (pop)  main_full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) main_data <= in_data;
  end
`endif

endmodule

// File: rtl/umi_demux.sv
// Registered 1-to-N UMI demultiplexer; port index taken from dstaddr[IDOFFSET +: $clog2(N)].
// Optional skid entry via UMI_DEMUX_SKID_EN (see umi_demux_stage).
module umi_demux
  import umi_pkg::*;
#(
  parameter int DW       = UMI_DW,
  parameter int CW       = UMI_CW,
  parameter int AW       = UMI_AW,
  parameter int N        = 4,
  parameter int IDOFFSET = 40
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          umi_in_valid,
  output logic          umi_in_ready,
  input  logic [CW-1:0] umi_in_cmd,
  input  logic [AW-1:0] umi_in_dstaddr,
  input  logic [AW-1:0] umi_in_srcaddr,
  input  logic [DW-1:0] umi_in_data,
  output logic [N-1:0]  umi_out_valid,
  input  logic [N-1:0]  umi_out_ready,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  input  logic          err_clear,
  output logic          err_drop,
  output logic [15:0]   err_count
);

  localparam int IW = $clog2(N);
  localparam int W  = CW + 2*AW + DW + N;

  logic [IW-1:0] idx;
  logic [3:0]    idx_ext;
  logic [N-1:0]  sel_in;
  logic          routable;
  logic          drop;

  logic          stage_valid;
  logic          stage_ready;
  logic [W-1:0]  stage_out;
  logic [N-1:0]  stage_sel;

  assign idx      = umi_in_dstaddr[IDOFFSET +: IW];
  assign idx_ext  = 4'(idx);
  assign sel_in   = N'(onehot_idx(idx_ext, N));
  assign routable = |sel_in;
  assign drop     = umi_in_valid & umi_in_ready & ~routable;

  umi_demux_stage #(.W(W)) u_stage (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (umi_in_valid & routable),
    .in_ready  (umi_in_ready),
    .in_data   ({sel_in, umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data}),
    .out_valid (stage_valid),
    .out_ready (stage_ready),
    .out_data  (stage_out)
  );

  assign {stage_sel, umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} = stage_out;

  // Only the selected port's ready can retire the entry.
  assign umi_out_valid = stage_valid ? stage_sel : '0;
  assign stage_ready   = |(umi_out_valid & umi_out_ready);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      err_drop  <= 1'b0;
      err_count <= '0;
    end else if (err_clear) begin
      err_drop  <= 1'b0;
      err_count <= drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      err_drop <= 1'b1;
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_umi_demux.sv
// Directed bench for umi_demux: N=4 instance for routing/handshake, N=3 instance for drops.
module tb_umi_demux;

  localparam int DW = 256;
  localparam int CW = 32;
  localparam int AW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nreset;

  // N=4 instance
  logic          a_in_valid, a_in_ready;
  logic [CW-1:0] a_in_cmd;
  logic [AW-1:0] a_in_dst, a_in_src;
  logic [DW-1:0] a_in_data;
  logic [3:0]    a_out_valid, a_out_ready;
  logic [CW-1:0] a_out_cmd;
  logic [AW-1:0] a_out_dst, a_out_src;
  logic [DW-1:0] a_out_data;
  logic          a_err_clear, a_err_drop;
  logic [15:0]   a_err_count;

  // N=3 instance
  logic          b_in_valid, b_in_ready;
  logic [AW-1:0] b_in_dst;
  logic [2:0]    b_out_valid, b_out_ready;
  logic [CW-1:0] b_out_cmd;
  logic [AW-1:0] b_out_dst, b_out_src;
  logic [DW-1:0] b_out_data;
  logic          b_err_clear, b_err_drop;
  logic [15:0]   b_err_count;

  umi_demux #(.DW(DW), .CW(CW), .AW(AW), .N(4), .IDOFFSET(40)) u_dut (
    .clk(clk), .nreset(nreset),
    .umi_in_valid(a_in_valid), .umi_in_ready(a_in_ready),
    .umi_in_cmd(a_in_cmd), .umi_in_dstaddr(a_in_dst),
    .umi_in_srcaddr(a_in_src), .umi_in_data(a_in_data),
    .umi_out_valid(a_out_valid), .umi_out_ready(a_out_ready),
    .umi_out_cmd(a_out_cmd), .umi_out_dstaddr(a_out_dst),
    .umi_out_srcaddr(a_out_src), .umi_out_data(a_out_data),
    .err_clear(a_err_clear), .err_drop(a_err_drop), .err_count(a_err_count)
  );

  umi_demux #(.DW(DW), .CW(CW), .AW(AW), .N(3), .IDOFFSET(40)) u_dut3 (
    .clk(clk), .nreset(nreset),
    .umi_in_valid(b_in_valid), .umi_in_ready(b_in_ready),
    .umi_in_cmd(32'h0000_0033), .umi_in_dstaddr(b_in_dst),
    .umi_in_srcaddr(64'h0), .umi_in_data({DW{1'b0}}),
    .umi_out_valid(b_out_valid), .umi_out_ready(b_out_ready),
    .umi_out_cmd(b_out_cmd), .umi_out_dstaddr(b_out_dst),
    .umi_out_srcaddr(b_out_src), .umi_out_data(b_out_data),
    .err_clear(b_err_clear), .err_drop(b_err_drop), .err_count(b_err_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] dst_of(input int port, input int tag);
    return (64'(port) << 40) | 64'(tag);
  endfunction

  function automatic logic [DW-1:0] data_of(input int tag);
    return {8{32'hA5A5_0000 | 32'(tag)}};
  endfunction

  task automatic drive(input int port, input int tag);
    a_in_valid = 1'b1;
    a_in_cmd   = 32'hC000_0000 | 32'(tag);
    a_in_dst   = dst_of(port, tag);
    a_in_src   = 64'h5000 | 64'(tag);
    a_in_data  = data_of(tag);
  endtask

  // Compares the shared output payload against packet (port, tag).
  task automatic check_pkt(input string tag_s, input int port, input int tag);
    check({tag_s, "_valid"}, a_out_valid, 4'b0001 << port);
    check({tag_s, "_cmd"},   a_out_cmd,   32'hC000_0000 | 32'(tag));
    check({tag_s, "_dst"},   a_out_dst,   dst_of(port, tag));
    check({tag_s, "_src"},   a_out_src,   64'h5000 | 64'(tag));
    check({tag_s, "_data"},  a_out_data,  data_of(tag));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0;
    a_in_valid = 1'b0; a_in_cmd = '0; a_in_dst = '0; a_in_src = '0; a_in_data = '0;
    a_out_ready = 4'hF; a_err_clear = 1'b0;
    b_in_valid = 1'b0; b_in_dst = '0; b_out_ready = 3'b111; b_err_clear = 1'b0;
    repeat (3) step();
    check("rst_valid", a_out_valid, 4'b0000);
    check("rst_drop",  a_err_drop,  1'b0);
    check("rst_count", a_err_count, 16'd0);
    nreset = 1'b1;
    step();
    check("rst_in_ready", a_in_ready, 1'b1);

    // single packet to port 2
    drive(2, 1);
    #1 check("single_in_ready", a_in_ready, 1'b1);
    step();
    a_in_valid = 1'b0;
    check_pkt("single", 2, 1);
    step();
    check("single_gone", a_out_valid, 4'b0000);

    // stall on port 1 while other ports are ready
    a_out_ready = 4'b1101;
    drive(1, 2);
    step();
    check_pkt("stall_first", 1, 2);
    drive(3, 3);
    #1;
`ifdef UMI_DEMUX_SKID_EN
    check("stall_skid_accept", a_in_ready, 1'b1);
    step();
    drive(0, 4);
    #1;
`endif
    check("stall_in_ready", a_in_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_pkt("stall_hold", 1, 2);
      check("stall_hold_rdy", a_in_ready, 1'b0);
    end
    a_out_ready = 4'hF;
    #1;
`ifdef UMI_DEMUX_SKID_EN
    check("stall_release_rdy", a_in_ready, 1'b0);
    step();
    check_pkt("stall_second", 3, 3);
    check("stall_skid_free", a_in_ready, 1'b1);
    step();
    a_in_valid = 1'b0;
    check_pkt("stall_third", 0, 4);
`else
    check("stall_release_rdy", a_in_ready, 1'b1);
    step();
    a_in_valid = 1'b0;
    check_pkt("stall_second", 3, 3);
`endif
    step();
    check("stall_empty", a_out_valid, 4'b0000);

    // back-to-back, one port per cycle
    for (int p = 0; p < 4; p++) begin
      drive(p, 16 + p);
      #1 check("b2b_in_ready", a_in_ready, 1'b1);
      step();
      check_pkt("b2b", p, 16 + p);
    end
    a_in_valid = 1'b0;
    step();
    check("b2b_empty", a_out_valid, 4'b0000);

    // N=3: out-of-range index drops
    b_in_dst = dst_of(3, 9);
    b_in_valid = 1'b1;
    #1 check("drop_in_ready", b_in_ready, 1'b1);
    step();
    b_in_valid = 1'b0;
    check("drop_valid", b_out_valid, 3'b000);
    check("drop_flag",  b_err_drop,  1'b1);
    check("drop_count", b_err_count, 16'd1);
    b_err_clear = 1'b1;
    step();
    b_err_clear = 1'b0;
    check("clear_flag",  b_err_drop,  1'b0);
    check("clear_count", b_err_count, 16'd0);
    b_in_valid = 1'b1;
    repeat (65536) step();
    b_in_valid = 1'b0;
    check("sat_count", b_err_count, 16'hFFFF);
    check("sat_valid", b_out_valid, 3'b000);
    b_err_clear = 1'b1;
    b_in_valid = 1'b1;
    step();
    b_err_clear = 1'b0;
    b_in_valid = 1'b0;
    check("clear_drop_flag",  b_err_drop,  1'b0);
    check("clear_drop_count", b_err_count, 16'd1);

    // ready only on a non-selected port
    a_out_ready = 4'b0001;
    drive(2, 5);
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_pkt("nonsel_hold", 2, 5);
      step();
    end
    check("nonsel_still", a_out_valid, 4'b0100);

    // reset with a full stage and a nonzero error count
    nreset = 1'b0;
    step();
    check("midrst_valid", a_out_valid, 4'b0000);
    check("midrst_count", b_err_count, 16'd0);
    check("midrst_drop",  b_err_drop,  1'b0);
    nreset = 1'b1;
    step();
    check("midrst_after", a_out_valid, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
